reg_bank: RTL and testbench

//   General-purpose register file for the KGP-RISC datapath: 32 x 32-bit registers.

---
 rtl/reg_bank.sv | 37 +++
 tb/tb_reg_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// KGP-RISC general-purpose register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module reg_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  output logic [DATA_WIDTH-1:0] rdDataA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] rdDataB
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];

  // Register 0 is ordinary storage; there is no hardwired zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite) begin
      regs[wrAddr] <= wrData;
    end
  end

  // No write bypass: a same-cycle read sees the old value until the edge.
  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: reset clearing, write/read ordering,
// boundary registers 0 and 31, and asynchronous reset between and on clock edges.
module tb_reg_bank;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [4:0]  rdAddrA;
  logic [31:0] rdDataA;
  logic [4:0]  rdAddrB;
  logic [31:0] rdDataB;

  int total = 0;
  int bad   = 0;

  reg_bank #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .RegWrite(RegWrite),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrA (rdAddrA),
    .rdDataA (rdDataA),
    .rdAddrB (rdAddrB),
    .rdDataB (rdDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite = 1'b1;
    wrAddr   = addr;
    wrData   = data;
    step();
    RegWrite = 1'b0;
  endtask

  initial begin
    // Scenario 1: held in reset with a write attempt pending.
    reset    = 1'b0;
    RegWrite = 1'b1;
    wrAddr   = 5'd3;
    wrData   = 32'h0000_00FF;
    rdAddrA  = 5'd3;
    rdAddrB  = 5'd7;
    repeat (2) step();
    check("rst_a_reg3", rdDataA, 32'h0);
    check("rst_b_reg7", rdDataB, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rdAddrA = 5'(i);
      #1;
      check($sformatf("rst_clear_r%0d", i), rdDataA, 32'h0);
    end

    @(negedge clk);
    RegWrite = 1'b0;
    reset    = 1'b1;
    rdAddrA  = 5'd3;
    step();
    check("reg3_write_ignored", rdDataA, 32'h0);

    // Scenario 2: first write after release.
    writeReg(5'd10, 32'h15);
    rdAddrA = 5'd15;
    rdAddrB = 5'd10;
    #1;
    check("s2_a_reg15", rdDataA, 32'h0);
    check("s2_b_reg10", rdDataB, 32'h15);

    // Scenario 3: read and write the same register, no bypass.
    @(negedge clk);
    RegWrite = 1'b1;
    wrAddr   = 5'd15;
    wrData   = 32'h3;
    rdAddrA  = 5'd15;
    #1;
    check("s3_before_edge", rdDataA, 32'h0);
    step();
    RegWrite = 1'b0;
    check("s3_after_edge", rdDataA, 32'h3);
    check("s3_b_unchanged", rdDataB, 32'h15);

    // Scenario 4: disabled writes leave storage alone.
    @(negedge clk);
    RegWrite = 1'b0;
    wrAddr   = 5'd10;
    wrData   = 32'hDEAD_BEEF;
    repeat (3) step();
    check("s4_no_write", rdDataB, 32'h15);

    // Scenario 5: boundary registers 0 and 31.
    writeReg(5'd0, 32'hA5A5_A5A5);
    writeReg(5'd31, 32'hFFFF_FFFF);
    rdAddrA = 5'd0;
    rdAddrB = 5'd31;
    #1;
    check("s5_a_reg0", rdDataA, 32'hA5A5_A5A5);
    check("s5_b_reg31", rdDataB, 32'hFFFF_FFFF);
    rdAddrA = 5'd31;
    #1;
    check("s5_same_a", rdDataA, 32'hFFFF_FFFF);
    check("s5_same_b", rdDataB, 32'hFFFF_FFFF);
    rdAddrA = 5'd10;
    rdAddrB = 5'd15;
    #1;
    check("s5_keep_reg10", rdDataA, 32'h15);
    check("s5_keep_reg15", rdDataB, 32'h3);

    // Scenario 6: asynchronous reset between edges.
    rdAddrA = 5'd0;
    rdAddrB = 5'd31;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_a_reg0", rdDataA, 32'h0);
    check("s6_async_b_reg31", rdDataB, 32'h0);

    // Write attempted on an edge while reset is held.
    RegWrite = 1'b1;
    wrAddr   = 5'd5;
    wrData   = 32'h77;
    rdAddrA  = 5'd5;
    step();
    check("s6_held_write", rdDataA, 32'h0);

    @(negedge clk);
    RegWrite = 1'b0;
    reset    = 1'b1;
    step();
    check("s6_release_reg31", rdDataB, 32'h0);
    check("s6_release_reg5", rdDataA, 32'h0);
    rdAddrA = 5'd10;
    #1;
    check("s6_release_reg10", rdDataA, 32'h0);

    writeReg(5'd31, 32'h1234_5678);
    check("s6_rewrite_reg31", rdDataB, 32'h1234_5678);

    // Reset asserted coincident with a write edge: reset wins.
    @(negedge clk);
    RegWrite = 1'b1;
    wrAddr   = 5'd31;
    wrData   = 32'hCAFE_F00D;
    @(posedge clk);
    reset = 1'b0;
    #1;
    RegWrite = 1'b0;
    check("coincident_reset", rdDataB, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("coincident_after", rdDataB, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
